// File: rtl/rom_seq_pkg.sv
// rom_seq_pkg: shared types and default widths for the ROM burst sequencer.
// Holds the FSM state encoding and the address/data/count width defaults.
package rom_seq_pkg;

    localparam int ADDR_W_DEF = 4;
    localparam int DATA_W_DEF = 8;
    localparam int CNT_W_DEF  = ADDR_W_DEF + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_SEND  = 2'd2,
        S_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/rom_sequencer.sv
// rom_sequencer: walks an external async ROM from first to last (with wrap)
// and offers each byte to a consumer over a valid/ready handshake.
module rom_sequencer
    import rom_seq_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] first_i,
    input  logic [ADDR_W-1:0] last_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [DATA_W-1:0] mem_data_i,
    output logic [DATA_W-1:0] tx_data_o,
    output logic              tx_valid_o,
    input  logic              tx_ready_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [ADDR_W:0]   count_o
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] last_q, last_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;

    // State and datapath registers; reset clears every visible output.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            last_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            last_q  <= last_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and datapath updates for the IDLE/FETCH/SEND/DONE walk.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        last_d  = last_q;
        data_d  = data_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    addr_d  = first_i;
                    last_d  = last_i;
                    cnt_d   = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                data_d  = mem_data_i;
                valid_d = 1'b1;
                state_d = S_SEND;
            end
            S_SEND: begin
                if (valid_q && tx_ready_i) begin
                    valid_d = 1'b0;
                    cnt_d   = cnt_q + 1'b1;
                    if (addr_q == last_q) begin
                        state_d = S_DONE;
                    end else begin
                        // natural overflow gives the wrap to address 0
                        addr_d  = addr_q + 1'b1;
                        state_d = S_FETCH;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign mem_addr_o = addr_q;
    assign tx_data_o  = data_q;
    assign tx_valid_o = valid_q;
    assign busy_o     = (state_q != S_IDLE);
    assign done_o     = (state_q == S_DONE);
    assign count_o    = cnt_q;

endmodule

// File: tb/tb_rom_sequencer.sv
// tb_rom_sequencer: scoreboard bench for rom_sequencer with a modelled
// async ROM holding 0x41..0x49, 0x50..0x56 at addresses 0..15.
module tb_rom_sequencer;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] first;
    logic [3:0] last;
    logic [3:0] mem_addr;
    logic [7:0] mem_data;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       done;
    logic [4:0] count;

    int checks = 0;
    int errors = 0;
    int hs_n   = 0;
    int done_n = 0;
    logic [7:0] exp_q[$];

    function automatic logic [7:0] rom_val(input logic [3:0] a);
        if (a < 4'd9) return 8'h41 + {4'd0, a};
        return 8'h50 + {4'd0, a} - 8'd9;
    endfunction

    assign mem_data = rom_val(mem_addr);

    rom_sequencer #(.ADDR_W(4), .DATA_W(8)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .start_i    (start),
        .first_i    (first),
        .last_i     (last),
        .mem_addr_o (mem_addr),
        .mem_data_i (mem_data),
        .tx_data_o  (tx_data),
        .tx_valid_o (tx_valid),
        .tx_ready_i (tx_ready),
        .busy_o     (busy),
        .done_o     (done),
        .count_o    (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at the negedge: scoreboard pop on handshake, count done pulses.
    task automatic sample();
        if (tx_valid && tx_ready) begin
            if (exp_q.size() == 0) begin
                check("extra_byte", {24'd0, tx_data}, 32'hFFFF_FFFF);
            end else begin
                check("tx_data", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
            end
            hs_n++;
        end
        if (done) done_n++;
    endtask

    task automatic run_burst(input int f, input int l, input int stall_at,
                             input int stall_n, input bit repulse);
        int len;
        int cyc;
        int stalled;
        len = ((l - f) & 15) + 1;
        for (int i = 0; i < len; i++) exp_q.push_back(rom_val(4'((f + i) & 15)));
        hs_n = 0;
        done_n = 0;
        stalled = 0;
        cyc = 0;
        tx_ready = 1'b1;
        start = 1'b1;
        first = 4'(f);
        last = 4'(l);
        @(posedge clk); #1;
        start = 1'b0;
        first = 4'($urandom);
        last = 4'($urandom);
        while (done_n == 0 && cyc < 400) begin
            if (stall_at >= 0 && hs_n == stall_at && tx_valid &&
                stalled < stall_n) begin
                tx_ready = 1'b0;
                stalled++;
                if (exp_q.size() > 0)
                    check("hold_data", {24'd0, tx_data}, {24'd0, exp_q[0]});
            end else begin
                tx_ready = 1'b1;
            end
            if (repulse && cyc == 3) begin
                start = 1'b1;
                first = 4'd5;
                last = 4'd5;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            sample();
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        check("burst_timeout", {31'd0, cyc < 400}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            sample();
        end
        check("done_pulses", done_n, 32'd1);
        check("bytes", hs_n, len);
        check("count", {27'd0, count}, len);
        check("queue_empty", exp_q.size(), 32'd0);
        check("idle_after", {31'd0, busy}, 32'd0);
        if (stall_at >= 0) check("stall_cycles", stalled, stall_n);
        exp_q.delete();
        @(posedge clk); #1;
    endtask

    initial begin
        int cyc;
        rst_n = 1'b0;
        start = 1'b0;
        first = '0;
        last = '0;
        tx_ready = 1'b1;
        #12;
        check("rst_valid", {31'd0, tx_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_data", {24'd0, tx_data}, 32'd0);
        check("rst_count", {27'd0, count}, 32'd0);
        check("rst_addr", {28'd0, mem_addr}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_burst(0, 2, -1, 0, 1'b0);
        run_burst(14, 1, -1, 0, 1'b0);
        run_burst(9, 9, -1, 0, 1'b0);
        run_burst(0, 15, 2, 5, 1'b0);
        run_burst(0, 7, -1, 0, 1'b1);

        // Reset during SEND of the second byte.
        exp_q.push_back(rom_val(4'd0));
        hs_n = 0;
        cyc = 0;
        tx_ready = 1'b1;
        start = 1'b1;
        first = 4'd0;
        last = 4'd5;
        @(posedge clk); #1;
        start = 1'b0;
        while (!(hs_n == 1 && tx_valid) && cyc < 50) begin
            @(negedge clk);
            sample();
            @(posedge clk); #1;
            cyc++;
        end
        check("rst_seek_timeout", {31'd0, cyc < 50}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", {31'd0, tx_valid}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_done", {31'd0, done}, 32'd0);
        check("mid_rst_data", {24'd0, tx_data}, 32'd0);
        check("mid_rst_count", {27'd0, count}, 32'd0);
        check("mid_rst_addr", {28'd0, mem_addr}, 32'd0);
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("no_resume", {31'd0, busy}, 32'd0);
        check("no_resume_valid", {31'd0, tx_valid}, 32'd0);

        run_burst(3, 3, -1, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
